dcache_responder: RTL and testbench

- Processor-side data memory responder for the pipelined RISC-V core.
- Receives the Memory-stage load/store request (address = ALU result, write data = forwarded RS2) and drives the waitrequest that freezes the Execute/Memory pipeline registers.
- Internally a direct-mapped, write-through, no-write-allocate cache with multi-word lines, backed by a pipelined Avalon-style memory port.
- Hits complete with zero wait; misses and stores stall the core until memory completes.

---
 rtl/dcache_pkg.sv | 50 +++++
 rtl/dcache_store.sv | 46 ++++
 rtl/dcache_responder.sv | 144 ++++++++++++++
 tb/tb_dcache_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the
// direct-mapped write-through data cache responder.
package dcache_pkg;

  localparam int INDEX_BITS = 6;
  localparam int OFFSET_WORDS_BITS = 2;
  localparam int TAG_BITS =
    32 - 2 - OFFSET_WORDS_BITS - INDEX_BITS;
  localparam int LINE_WORDS = 1 << OFFSET_WORDS_BITS;
  localparam int NUM_LINES = 1 << INDEX_BITS;
  localparam int CNT_BITS = OFFSET_WORDS_BITS + 1;

  localparam logic [CNT_BITS-1:0] CNT_FULL =
    CNT_BITS'(LINE_WORDS);
  localparam logic [CNT_BITS-1:0] CNT_LAST =
    CNT_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  function automatic logic [INDEX_BITS-1:0] index_of(
    input logic [31:0] a
  );
    return a[INDEX_BITS+OFFSET_WORDS_BITS+1 :
             OFFSET_WORDS_BITS+2];
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_of(
    input logic [31:0] a
  );
    return a[31 -: TAG_BITS];
  endfunction

  function automatic logic [OFFSET_WORDS_BITS-1:0] word_of(
    input logic [31:0] a
  );
    return a[OFFSET_WORDS_BITS+1:2];
  endfunction

  function automatic logic [31:0] line_base(
    input logic [31:0] a
  );
    return {a[31:OFFSET_WORDS_BITS+2],
            {(OFFSET_WORDS_BITS+2){1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag, valid and data arrays: combinational lookup,
// synchronous word write and line set/invalidate.
module dcache_store
  import dcache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INDEX_BITS-1:0]        index,
  input  logic [TAG_BITS-1:0]          tag,
  input  logic [OFFSET_WORDS_BITS-1:0] word,
  output logic                         hit,
  output logic [31:0]                  rd_word,
  input  logic                         we,
  input  logic [OFFSET_WORDS_BITS-1:0] w_word,
  input  logic [31:0]                  w_data,
  input  logic                         set,
  input  logic                         inv
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_BITS-1:0]  tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES][LINE_WORDS];

  assign hit = valid[index] && (tags[index] == tag);
  assign rd_word = data[index][word];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (set) begin
      valid[index] <= 1'b1;
    end else if (inv) begin
      valid[index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      data[index][w_word] <= w_data;
    end
    if (set) begin
      tags[index] <= tag;
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Memory-stage responder: zero-wait read hits, line fills
// on read miss, write-through stores with no allocate.
module dcache_responder
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        p_read,
  input  logic        p_write,
  input  logic [31:0] p_address,
  input  logic [31:0] p_writedata,
  output logic [31:0] p_readdata,
  output logic        p_waitrequest,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_address,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid
);

  state_t              state;
  logic [31:0]         addr_q;
  logic [31:0]         data_q;
  logic [CNT_BITS-1:0] issue_cnt;
  logic [CNT_BITS-1:0] recv_cnt;

  logic                         req_wr;
  logic                         req_rd;
  logic [31:0]                  look;
  logic                         hit;
  logic [31:0]                  rd_word;
  logic                         fill_beat;
  logic                         last_beat;
  logic                         wr_done;
  logic                         we;
  logic [OFFSET_WORDS_BITS-1:0] w_word;
  logic [31:0]                  w_data;
  logic                         inv;

  assign req_wr = p_write;
  assign req_rd = p_read & ~p_write;

  // Held core address in IDLE, latched one otherwise.
  assign look = (state == IDLE) ? p_address : addr_q;

  assign fill_beat = (state == FILL) && m_readdatavalid &&
                     (recv_cnt < CNT_FULL);
  assign last_beat = fill_beat && (recv_cnt == CNT_LAST);
  assign wr_done = (state == WRITE) && !m_waitrequest;

  assign we = fill_beat || (wr_done && hit);
  assign w_word = (state == FILL) ?
                  recv_cnt[OFFSET_WORDS_BITS-1:0] :
                  word_of(addr_q);
  assign w_data = (state == FILL) ? m_readdata : data_q;
  assign inv = (state == IDLE) && req_rd && !hit;

  dcache_store u_store (
    .clk     (clk),
    .rst     (rst),
    .index   (index_of(look)),
    .tag     (tag_of(look)),
    .word    (word_of(look)),
    .hit     (hit),
    .rd_word (rd_word),
    .we      (we),
    .w_word  (w_word),
    .w_data  (w_data),
    .set     (last_beat),
    .inv     (inv)
  );

  always_comb begin
    p_waitrequest = 1'b0;
    if (req_wr) begin
      p_waitrequest = !wr_done;
    end else if (req_rd) begin
      p_waitrequest = !((state == IDLE) && hit);
    end
  end

  assign p_readdata =
    ((state == IDLE) && req_rd && hit) ? rd_word : '0;

  assign m_read = (state == FILL) && (issue_cnt < CNT_FULL);
  assign m_write = (state == WRITE);
  assign m_writedata = m_write ? data_q : '0;

  always_comb begin
    m_address = '0;
    if (m_read) begin
      m_address = {addr_q[31:OFFSET_WORDS_BITS+2],
                   issue_cnt[OFFSET_WORDS_BITS-1:0],
                   2'b00};
    end else if (m_write) begin
      m_address = addr_q & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_wr) begin
            addr_q <= p_address;
            data_q <= p_writedata;
            state  <= WRITE;
          end else if (req_rd && !hit) begin
            addr_q    <= line_base(p_address);
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (m_read && !m_waitrequest) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (fill_beat) begin
            recv_cnt <= recv_cnt + 1'b1;
          end
          if (last_beat) begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (!m_waitrequest) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: pipelined memory model plus
// a line-presence/word-value reference of the cache.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p_read = 1'b0;
  logic        p_write = 1'b0;
  logic [31:0] p_address = '0;
  logic [31:0] p_writedata = '0;
  logic [31:0] p_readdata;
  logic        p_waitrequest;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_address;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;

  dcache_responder dut (
    .clk             (clk),
    .rst             (rst),
    .p_read          (p_read),
    .p_write         (p_write),
    .p_address       (p_address),
    .p_writedata     (p_writedata),
    .p_readdata      (p_readdata),
    .p_waitrequest   (p_waitrequest),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_address       (m_address),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 2;
  int stall_until = 0;
  bit rnd_stall = 0;
  int rdv_count = 0;

  typedef struct {
    logic [31:0] d;
    int          due;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] rbeats[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] refm[logic [31:0]];
  logic [31:0] cl[int];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : pat(a);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a >> 4) & 32'h3F);
  endfunction

  function automatic bit present(input logic [31:0] a);
    return cl.exists(idx(a)) && cl[idx(a)] == (a & ~32'hF);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: commands accepted on the coming edge,
  // in-order responses lat edges later.
  always @(negedge clk) begin
    if (!rst) begin
      rq.delete();
      m_readdatavalid = 1'b0;
      m_waitrequest = 1'b0;
      m_readdata = '0;
    end else begin
      m_waitrequest = (cyc + 1 <= stall_until) ||
        (rnd_stall && $urandom_range(0, 3) == 0);
      if (m_read && !m_waitrequest) begin
        rq.push_back('{mem_rd(m_address), cyc + 1 + lat});
        rbeats.push_back(m_address);
      end
      if (m_write && !m_waitrequest) begin
        mem[m_address] = m_writedata;
        wa.push_back(m_address);
        wd.push_back(m_writedata);
      end
      m_readdatavalid = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc + 1) begin
        m_readdatavalid = 1'b1;
        m_readdata = rq[0].d;
        void'(rq.pop_front());
        rdv_count++;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic access(input bit wr,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd,
                        output int waits);
    p_write = wr;
    p_read = !wr;
    p_address = a;
    p_writedata = d;
    waits = 0;
    rd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!p_waitrequest) begin
        rd = p_readdata;
        break;
      end
      waits++;
      if (waits > 300) begin
        total++;
        bad++;
        $display("FAIL timeout addr=%h waits=%0d", a, waits);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    p_read = 1'b0;
    p_write = 1'b0;
  endtask

  task automatic do_op(input string nm,
                       input bit wr,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input int stall,
                       input int ew,
                       input int erb,
                       input logic [31:0] ed);
    int w;
    int r0;
    int w0;
    logic [31:0] rd;
    logic [31:0] base;
    base = a & ~32'hF;
    r0 = rbeats.size();
    w0 = wa.size();
    stall_until = cyc + stall;
    access(wr, a, d, rd, w);
    if (ew >= 0) chk({nm, "/waits"}, w, ew);
    else chk({nm, "/stalled"}, 32'(w > 0), 1);
    chk({nm, "/rbeats"}, rbeats.size() - r0, erb);
    if (erb == 4 && rbeats.size() - r0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s/beat%0d", nm, k),
            rbeats[r0 + k], base + 32'(4 * k));
      end
    end
    if (wr) begin
      chk({nm, "/wbeats"}, wa.size() - w0, 1);
      if (wa.size() > w0) begin
        chk({nm, "/waddr"}, wa[w0], a & ~32'h3);
        chk({nm, "/wdata"}, wd[w0], d);
      end
      refm[a & ~32'h3] = d;
    end else begin
      chk({nm, "/wbeats"}, wa.size() - w0, 0);
      chk({nm, "/rdata"}, rd, ed);
      if (!present(a)) cl[idx(a)] = base;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    int          stall;
    int          ew;
    int          erb;
    logic [31:0] ed;
  } vec_t;

  vec_t tv[9];

  logic [31:0] bases[5];

  initial begin
    int n0;
    int i;
    tv[0] = '{0, 32'h100, 0, 0, -1, 4, pat(32'h100)};
    tv[1] = '{0, 32'h10C, 0, 0, 0, 0, pat(32'h10C)};
    tv[2] = '{1, 32'h108, 32'hDEADBEEF, 3, 3, 0, 0};
    tv[3] = '{0, 32'h108, 0, 0, 0, 0, 32'hDEADBEEF};
    tv[4] = '{1, 32'h2000, 32'h1234_5678, 0, 1, 0, 0};
    tv[5] = '{0, 32'h2000, 0, 0, -1, 4, 32'h1234_5678};
    tv[6] = '{0, 32'h100, 0, 0, -1, 4, pat(32'h100)};
    tv[7] = '{0, 32'h504, 0, 0, -1, 4, pat(32'h504)};
    tv[8] = '{0, 32'h108, 0, 0, -1, 4, 32'hDEADBEEF};
    bases[0] = 32'h100;
    bases[1] = 32'h500;
    bases[2] = 32'h900;
    bases[3] = 32'h2000;
    bases[4] = 32'h2040;

    repeat (2) @(posedge clk);
    #1;
    chk("rst/m_read", m_read, 0);
    chk("rst/m_write", m_write, 0);
    chk("rst/p_wait", p_waitrequest, 0);
    chk("rst/m_address", m_address, 0);
    chk("rst/m_writedata", m_writedata, 0);
    chk("rst/p_readdata", p_readdata, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    lat = 2;
    for (int k = 0; k < 6; k++) begin
      do_op($sformatf("row%0d", k), tv[k].wr, tv[k].a,
            tv[k].d, tv[k].stall, tv[k].ew, tv[k].erb,
            tv[k].ed);
    end

    // Abort a fill of 0x500 after two of four responses.
    stall_until = cyc;
    p_address = 32'h500;
    p_read = 1'b1;
    n0 = rdv_count;
    i = 0;
    while (rdv_count - n0 < 2 && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("abort/reached", 32'(i < 100), 1);
    chk("abort/filling", m_read | (p_waitrequest), 1);
    rst = 1'b0;
    p_read = 1'b0;
    #1;
    chk("abort/m_read", m_read, 0);
    chk("abort/p_wait", p_waitrequest, 0);
    chk("abort/m_address", m_address, 0);
    chk("abort/m_write", m_write, 0);
    cl.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 6; k < 9; k++) begin
      do_op($sformatf("row%0d", k), tv[k].wr, tv[k].a,
            tv[k].d, tv[k].stall, tv[k].ew, tv[k].erb,
            tv[k].ed);
    end

    rnd_stall = 1;
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      bit wr;
      int ew;
      int erb;
      a = bases[$urandom_range(0, 4)] +
          32'(4 * $urandom_range(0, 3));
      wr = ($urandom_range(0, 2) == 0);
      lat = $urandom_range(1, 4);
      ew = (!wr && present(a)) ? 0 : -1;
      erb = (!wr && !present(a)) ? 4 : 0;
      do_op($sformatf("rnd%0d", k), wr, a, $urandom, 0,
            ew, erb, ref_rd(a));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
